mem_port_arbiter: RTL

//   Shares one synchronous memory port between instruction fetch (IF, port 0)
//   and data access (DM, port 1) in the multi-cycle CPU. Arbitrates requests,

---
 rtl/mem_port_arbiter_pkg.sv | 13 +
 rtl/mem_port_arbiter_mux.sv | 13 +
 rtl/mem_port_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states and requester port IDs.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// Generic 2:1 multiplexer used for the shared memory address (a1 when s=1).
module mux2to1_d32 #(
  parameter int N = 32
) (
  input  logic         s,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] a1,
  output logic [N-1:0] y
);

  assign y = s ? a1 : a0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch and data access.
// Define DATA_PRIORITY_EN for fixed DM-over-IF priority; default is round-robin.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_done,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          sel,
  output logic          busy
);

  localparam int CW = $clog2(MEM_LAT + 1);

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            last_q, last_d;
  logic            we_q, we_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            winner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= PORT_IF;
      last_q  <= PORT_DM;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
`ifdef DATA_PRIORITY_EN
    winner = dm_req ? PORT_DM : PORT_IF;
`else
    if (if_req && dm_req) winner = ~last_q;
    else                  winner = dm_req ? PORT_DM : PORT_IF;
`endif
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    mem_en  = 1'b0;
    mem_we  = 1'b0;
    if_done = 1'b0;
    dm_done = 1'b0;
    rdata   = rdata_q;
    case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          sel_d   = winner;
          last_d  = winner;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_en  = 1'b1;
        mem_we  = dm_we & sel_q;
        we_d    = dm_we & sel_q;
        cnt_d   = CW'(1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == CW'(MEM_LAT)) begin
          if_done = ~sel_q;
          dm_done = sel_q;
          // Read data is forwarded during the done cycle and held in rdata_q
          // afterwards, so it is valid together with the done pulse.
          if (!we_q) begin
            rdata_d = mem_rdata;
            rdata   = mem_rdata;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mux2to1_d32 #(.N(AW)) u_addr_mux (
    .s  (sel_q),
    .a0 (if_addr),
    .a1 (dm_addr),
    .y  (mem_addr)
  );

  assign mem_wdata = dm_wdata;
  assign sel       = sel_q;
  assign busy      = (state_q != IDLE);

endmodule
